// File: rtl/raster_engine.sv
// raster_engine: 1bpp frame-buffer rasteriser.
// Draw commands (CLEAR/PLOT/ERASE/RECT) render into an internal W x H bitmap.
// PRESENT streams the frame row-major as colour pixels with backpressure.
// Command port: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. Pixel port: a pixel transfers on a rising edge
// where pix_valid and pix_ready are both high; pixel data and flags hold
// steady while pix_valid is high and pix_ready is low.
module raster_engine #(
    parameter int                  XB       = 3,
    parameter int                  YB       = 3,
    parameter int                  PIX_BITS = 4,
    parameter logic [PIX_BITS-1:0] FG_COLOR = 4'hF,
    parameter logic [PIX_BITS-1:0] BG_COLOR = 4'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          cmd_op,
    input  logic [XB-1:0]       cmd_x0,
    input  logic [XB-1:0]       cmd_x1,
    input  logic [YB-1:0]       cmd_y0,
    input  logic [YB-1:0]       cmd_y1,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic [PIX_BITS-1:0] pix_data,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                frame_start,
    output logic                line_end,
    output logic                frame_end,
    output logic [1:0]          dbg_state
);

    localparam int W = 1 << XB;
    localparam int H = 1 << YB;

    localparam logic [2:0] OP_CLEAR   = 3'b001;
    localparam logic [2:0] OP_PLOT    = 3'b010;
    localparam logic [2:0] OP_ERASE   = 3'b011;
    localparam logic [2:0] OP_RECT    = 3'b100;
    localparam logic [2:0] OP_PRESENT = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_SCAN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [H-1:0][W-1:0]   r_bitmap;
    logic [XB-1:0]         r_x, r_xmin, r_xmax;
    logic [YB-1:0]         r_y, r_ymin, r_ymax;
    logic                  r_val;
    logic                  r_cmd_ready;
    logic                  r_pix_valid;
    logic [PIX_BITS-1:0]   r_pix_data;
    logic                  r_fs, r_le, r_fe;

    logic                  w_accept;
    logic                  w_is_nop;
    logic                  w_draw_done;
    logic                  w_clear_done;
    logic                  w_scan_last;
    logic [XB-1:0]         w_nx, w_xmin, w_xmax;
    logic [YB-1:0]         w_ny, w_ymin, w_ymax;

    assign w_accept     = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;
    assign w_is_nop     = (cmd_op == 3'b000) || (cmd_op[2:1] == 2'b11);
    assign w_draw_done  = (r_x == r_xmax) && (r_y == r_ymax);
    assign w_clear_done = (r_y == {YB{1'b1}});
    assign w_scan_last  = pix_ready && (r_x == {XB{1'b1}}) && (r_y == {YB{1'b1}});
    assign w_nx         = r_x + 1'b1;
    assign w_ny         = (r_x == {XB{1'b1}}) ? r_y + 1'b1 : r_y;
    assign w_xmin       = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
    assign w_xmax       = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
    assign w_ymin       = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
    assign w_ymax       = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;

    assign cmd_ready   = r_cmd_ready;
    assign pix_valid   = r_pix_valid;
    assign pix_data    = r_pix_data;
    assign frame_start = r_fs;
    assign line_end    = r_le;
    assign frame_end   = r_fe;
    assign dbg_state   = r_state;

    // {frame_start, line_end, frame_end} for the pixel at (x, y)
    function automatic logic [2:0] flags_for(input logic [XB-1:0] x, input logic [YB-1:0] y);
        return {(x == '0) && (y == '0), (x == {XB{1'b1}}), (x == {XB{1'b1}}) && (y == {YB{1'b1}})};
    endfunction

    function automatic logic [PIX_BITS-1:0] color_of(input logic b);
        return b ? FG_COLOR : BG_COLOR;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_is_nop) begin
                    case (cmd_op)
                        OP_CLEAR:                 w_next_state = S_CLEAR;
                        OP_PLOT, OP_ERASE, OP_RECT: w_next_state = S_DRAW;
                        OP_PRESENT:               w_next_state = S_SCAN;
                        default:                  w_next_state = S_IDLE;
                    endcase
                end
            end
            S_CLEAR: if (w_clear_done) w_next_state = S_IDLE;
            S_DRAW:  if (w_draw_done)  w_next_state = S_IDLE;
            S_SCAN:  if (w_scan_last)  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: command latch, bitmap writes, scan counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_val       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= BG_COLOR;
            r_fs        <= 1'b0;
            r_le        <= 1'b0;
            r_fe        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept && !w_is_nop) begin
                        r_cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_CLEAR: r_y <= '0;
                            OP_PLOT, OP_ERASE: begin
                                r_xmin <= cmd_x0;
                                r_xmax <= cmd_x0;
                                r_ymin <= cmd_y0;
                                r_ymax <= cmd_y0;
                                r_x    <= cmd_x0;
                                r_y    <= cmd_y0;
                                r_val  <= (cmd_op == OP_PLOT);
                            end
                            OP_RECT: begin
                                r_xmin <= w_xmin;
                                r_xmax <= w_xmax;
                                r_ymin <= w_ymin;
                                r_ymax <= w_ymax;
                                r_x    <= w_xmin;
                                r_y    <= w_ymin;
                                r_val  <= 1'b1;
                            end
                            OP_PRESENT: begin
                                r_x         <= '0;
                                r_y         <= '0;
                                r_pix_valid <= 1'b1;
                                r_pix_data  <= color_of(r_bitmap[0][0]);
                                {r_fs, r_le, r_fe} <= flags_for('0, '0);
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    r_bitmap[r_y] <= '0;
                    if (w_clear_done) r_cmd_ready <= 1'b1;
                    else              r_y <= r_y + 1'b1;
                end
                S_DRAW: begin
                    r_bitmap[r_y][r_x] <= r_val;
                    if (r_x == r_xmax) begin
                        r_x <= r_xmin;
                        if (r_y == r_ymax) r_cmd_ready <= 1'b1;
                        else               r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_scan_last) begin
                        r_pix_valid <= 1'b0;
                        {r_fs, r_le, r_fe} <= 3'b000;
                        r_cmd_ready <= 1'b1;
                        r_x <= '0;
                        r_y <= '0;
                    end else if (pix_ready) begin
                        r_x        <= w_nx;
                        r_y        <= w_ny;
                        r_pix_data <= color_of(r_bitmap[w_ny][w_nx]);
                        {r_fs, r_le, r_fe} <= flags_for(w_nx, w_ny);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
